cpu_core: RTL

Parametrised multi-cycle processor core: the successor to the fixed 16-bit fetch/decode/execute CPU top. It runs a FETCH/DECODE/EXECUTE state machine over an external instruction memory with a valid handshake that tolerates wait states. It adds a DATA_W-wide 8-entry register file, shifted-operand ALU ops, an immediate load, flag-conditional execution and branching. It sits between the instruction ROM and the system, and exposes flags and retire status for debug and verification.

---
 rtl/cpu_core.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle FETCH/DECODE/EXECUTE core with an 8-entry register file,
// shifted-operand ALU, 8-bit immediate load, flag-conditional execution and jumps.
module cpu_core #(
   parameter int          DATA_W   = 16,
   parameter int          PC_W     = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   input  logic            imem_valid,
   output logic            negative,
   output logic            zero,
   output logic            carry,
   output logic            overflow,
   output logic [PC_W-1:0] pc,
   output logic            retire
);
   localparam int MSB = DATA_W - 1;

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE} state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MOVI, OP_JMP} op_t;

   typedef struct packed {
      logic [1:0] cond;
      op_t        op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [1:0] sh;
   } instr_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   state_t                   state, state_n;
   instr_t                   ir;
   flags_t                   flags, alu_flags, flg_q;
   logic [7:0][DATA_W-1:0]   rf;
   logic [PC_W-1:0]          pc_q, tgt, tgt_q;
   logic [DATA_W-1:0]        a, b_raw, b, res, res_q;
   logic [DATA_W:0]          sum, diff;
   logic                     fc, fv, cond_ok, exec_q;

   // Operand read and ALU evaluation, consumed by DECODE and held for EXECUTE
   always_comb begin
      a     = (ir.rs1 == 3'd0) ? '0 : rf[ir.rs1];
      b_raw = (ir.rs2 == 3'd0) ? '0 : rf[ir.rs2];
      b     = b_raw << ir.sh;
      sum   = {1'b0, a} + {1'b0, b};
      diff  = {1'b0, a} - {1'b0, b};
      res   = '0;
      fc    = 1'b0;
      fv    = 1'b0;
      case (ir.op)
         OP_ADD: begin
            res = sum[MSB:0];
            fc  = sum[DATA_W];
            fv  = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
         end
         OP_SUB: begin
            res = diff[MSB:0];
            fc  = ~diff[DATA_W];
            fv  = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_SHL:  res = b;
         OP_MOVI: res = DATA_W'({ir.rs1, ir.rs2, ir.sh});
         default: res = '0;
      endcase
      alu_flags = {res[MSB], (res == '0), fc, fv};
      tgt       = PC_W'(a);
      case (ir.cond)
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = flags.z;
         2'b10:   cond_ok = flags.n;
         default: cond_ok = flags.c;
      endcase
   end

   always_comb begin
      state_n  = state;
      imem_req = 1'b0;
      retire   = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = ~reset;
            if (imem_valid) state_n = S_DECODE;
         end
         S_DECODE:  state_n = S_EXECUTE;
         S_EXECUTE: begin
            retire  = ~reset;
            state_n = S_FETCH;
         end
         default:   state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_FETCH;
         pc_q   <= PC_W'(RESET_PC);
         rf     <= '0;
         flags  <= '0;
         ir     <= '0;
         exec_q <= 1'b0;
         res_q  <= '0;
         flg_q  <= '0;
         tgt_q  <= '0;
      end else begin
         state <= state_n;
         if (state == S_FETCH && imem_valid) ir <= instr_t'(imem_data);
         if (state == S_DECODE) begin
            exec_q <= cond_ok;
            res_q  <= res;
            flg_q  <= alu_flags;
            tgt_q  <= tgt;
         end
         if (state == S_EXECUTE) begin
            // R0 is never written so it stays at its reset value of zero
            if (exec_q && ir.op != OP_JMP && ir.rd != 3'd0) rf[ir.rd] <= res_q;
            if (exec_q && ir.op != OP_MOVI && ir.op != OP_JMP) flags <= flg_q;
            pc_q <= (exec_q && ir.op == OP_JMP) ? tgt_q : pc_q + 1'b1;
         end
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign negative  = flags.n;
   assign zero      = flags.z;
   assign carry     = flags.c;
   assign overflow  = flags.v;
endmodule
